// File: rtl/lighting_pkg.sv
// Shared types and defaults for the smart lighting
// mode controller and its press classifier.
package lighting_pkg;

  localparam int DEBOUNCE_T_DEF = 100;
  localparam int SWITCH_T_DEF   = 5300;

  typedef enum logic [2:0] {
    RELEASED,
    PRESS_DB,
    HELD,
    LONG_HELD,
    RELEASE_DB
  } press_state_t;

  typedef enum logic [1:0] {
    AUTO_OFF,
    AUTO_ON,
    MANUAL_OFF,
    MANUAL_ON
  } light_state_t;

  function automatic logic is_manual(
    light_state_t s
  );
    return (s == MANUAL_OFF) ||
           (s == MANUAL_ON);
  endfunction

  function automatic logic lamp_on(
    light_state_t s
  );
    return (s == AUTO_ON) ||
           (s == MANUAL_ON);
  endfunction

endpackage

// File: rtl/lighting_mode_controller_if.sv
// Pin bundle between the lighting controller,
// its button/sensor inputs and the shutdown timer.
interface lighting_if;

  logic push_button;
  logic infravermelho;
  logic timer_expired;
  logic timer_en;
  logic led;
  logic mode;

  modport master (
    output push_button,
    output infravermelho,
    output timer_expired,
    input  timer_en,
    input  led,
    input  mode
  );

  modport slave (
    input  push_button,
    input  infravermelho,
    input  timer_expired,
    output timer_en,
    output led,
    output mode
  );

endinterface

// File: rtl/lighting_mode_controller_classifier.sv
// Push-button conditioning: sync, debounce and
// short/long press classification.
module button_press_classifier
  import lighting_pkg::*;
#(
  parameter int DEBOUNCE_T = DEBOUNCE_T_DEF,
  parameter int SWITCH_T   = SWITCH_T_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic short_evt_o,
  output logic long_evt_o
);

  localparam int MAXT =
    (DEBOUNCE_T > SWITCH_T) ? DEBOUNCE_T
                            : SWITCH_T;
  localparam int CW = $clog2(MAXT) + 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DB_LAST =
    cnt_t'(DEBOUNCE_T - 1);
  localparam cnt_t HOLD_LAST =
    cnt_t'(SWITCH_T - 1);

  logic s1_q, s_q;
  press_state_t st_q, st_d;
  cnt_t db_q, db_d;
  cnt_t hold_q, hold_d;
  logic lh_q, lh_d;
  logic short_q, short_d;
  logic long_q, long_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= 1'b0;
      s_q     <= 1'b0;
      st_q    <= RELEASED;
      db_q    <= '0;
      hold_q  <= '0;
      lh_q    <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      s1_q    <= btn_i;
      s_q     <= s1_q;
      st_q    <= st_d;
      db_q    <= db_d;
      hold_q  <= hold_d;
      lh_q    <= lh_d;
      short_q <= short_d;
      long_q  <= long_d;
    end
  end

  // db_q counts stable cycles at the new level;
  // lh_q remembers whether this press went long.
  always_comb begin
    st_d    = st_q;
    db_d    = db_q;
    hold_d  = hold_q;
    lh_d    = lh_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    unique case (st_q)
      RELEASED, PRESS_DB: begin
        if (!s_q) begin
          st_d = RELEASED;
          db_d = '0;
        end else if (db_q == DB_LAST) begin
          st_d   = HELD;
          db_d   = '0;
          hold_d = '0;
          lh_d   = 1'b0;
        end else begin
          st_d = PRESS_DB;
          db_d = db_q + cnt_t'(1);
        end
      end
      HELD, LONG_HELD, RELEASE_DB: begin
        if (!s_q) begin
          if (db_q == DB_LAST) begin
            st_d    = RELEASED;
            db_d    = '0;
            hold_d  = '0;
            lh_d    = 1'b0;
            short_d = !lh_q;
          end else begin
            st_d = RELEASE_DB;
            db_d = db_q + cnt_t'(1);
          end
        end else begin
          db_d = '0;
          st_d = lh_q ? LONG_HELD : HELD;
          if (!lh_q) begin
            if (hold_q == HOLD_LAST) begin
              st_d   = LONG_HELD;
              lh_d   = 1'b1;
              long_d = 1'b1;
            end else begin
              hold_d = hold_q + cnt_t'(1);
            end
          end
        end
      end
      default: begin
        st_d = RELEASED;
        db_d = '0;
      end
    endcase
  end

  assign short_evt_o = short_q;
  assign long_evt_o  = long_q;

endmodule

// File: rtl/lighting_mode_controller.sv
// Manual/automatic lamp sequencer driving an
// external auto-shutdown timer.
module lighting_mode_controller
  import lighting_pkg::*;
#(
  parameter int DEBOUNCE_T = DEBOUNCE_T_DEF,
  parameter int SWITCH_T   = SWITCH_T_DEF
) (
  input  logic      clk,
  input  logic      rst,
  lighting_if.slave bus
);

  logic short_evt;
  logic long_evt;
  logic ir_s1_q, ir_s_q;
  light_state_t st_q, st_d;
  logic led_q, mode_q, ten_q;

  button_press_classifier #(
    .DEBOUNCE_T(DEBOUNCE_T),
    .SWITCH_T  (SWITCH_T)
  ) u_cls (
    .clk        (clk),
    .rst        (rst),
    .btn_i      (bus.push_button),
    .short_evt_o(short_evt),
    .long_evt_o (long_evt)
  );

  // Outputs track the state and presence values
  // being loaded on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_s1_q <= 1'b0;
      ir_s_q  <= 1'b0;
      st_q    <= AUTO_OFF;
      led_q   <= 1'b0;
      mode_q  <= 1'b0;
      ten_q   <= 1'b0;
    end else begin
      ir_s1_q <= bus.infravermelho;
      ir_s_q  <= ir_s1_q;
      st_q    <= st_d;
      led_q   <= lamp_on(st_d);
      mode_q  <= is_manual(st_d);
      ten_q   <= (st_d == AUTO_ON) && !ir_s1_q;
    end
  end

  always_comb begin
    st_d = st_q;
    if (long_evt) begin
      st_d = is_manual(st_q) ? AUTO_OFF
                             : MANUAL_OFF;
    end else begin
      unique case (st_q)
        AUTO_OFF:
          if (ir_s_q) st_d = AUTO_ON;
        AUTO_ON:
          if (bus.timer_expired && !ir_s_q)
            st_d = AUTO_OFF;
        MANUAL_OFF:
          if (short_evt) st_d = MANUAL_ON;
        MANUAL_ON:
          if (short_evt) st_d = MANUAL_OFF;
      endcase
    end
  end

  assign bus.led      = led_q;
  assign bus.mode     = mode_q;
  assign bus.timer_en = ten_q;

endmodule

// File: doc/lighting_mode_controller.md
# lighting_mode_controller

Top-level sequencer for the smart lighting system. It conditions the raw push button into short-press and long-press events, holds the manual/automatic mode, and drives the lamp. In automatic mode it sequences the external auto-shutdown timer: it enables the timer while the lamp is on and no presence is detected, and turns the lamp off on the timer's expiry pulse.

## Interface
Parameters:
- DEBOUNCE_T, 100: consecutive stable cycles required to accept a button level change.
- SWITCH_T, 5300: debounced hold cycles that qualify a press as long (mode switch).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- push_button  input  1  raw, asynchronous, bouncing button; 1 = pressed.
- infravermelho  input  1  raw presence sensor; 1 = presence.
- timer_expired  input  1  expiry pulse from the auto-shutdown timer (its C output).
- timer_en  output  1  enable to the auto-shutdown timer.
- led  output  1  lamp drive; 1 = on.
- mode  output  1  0 = automatic, 1 = manual.

## Operation
- Input conditioning: push_button and infravermelho each pass through a 2-FF synchronizer (btn_s, ir_s). timer_expired is already synchronous and is used directly.
- Press classifier states: RELEASED, PRESS_DB, HELD, LONG_HELD, RELEASE_DB.
  - RELEASED→PRESS_DB when btn_s=1.
  - PRESS_DB→HELD after DEBOUNCE_T consecutive cycles with btn_s=1. Returns to RELEASED if btn_s=0 earlier; the debounce count clears.
  - In HELD, the hold counter increments each cycle from 0. When it reaches SWITCH_T-1, the classifier emits long_evt for 1 cycle and moves to LONG_HELD.
  - HELD or LONG_HELD → RELEASE_DB when btn_s=0.
  - RELEASE_DB→RELEASED after DEBOUNCE_T consecutive cycles with btn_s=0. The 1-cycle short_evt is emitted only if entry was from HELD. A return to btn_s=1 sends it back to the origin state; the hold count is preserved.
  - At most one event per physical press.
- Main FSM states: AUTO_OFF, AUTO_ON, MANUAL_OFF, MANUAL_ON.
  - AUTO_OFF→AUTO_ON when ir_s=1.
  - AUTO_ON→AUTO_OFF when timer_expired=1 and ir_s=0. Expiry while ir_s=1 is ignored.
  - MANUAL_OFF↔MANUAL_ON on short_evt.
  - long_evt: any AUTO_* → MANUAL_OFF; any MANUAL_* → AUTO_OFF.
  - short_evt in AUTO_* is ignored.
  - ir_s and timer_expired are ignored in MANUAL_*.
- Priority in a single cycle: long_evt > timer_expired > ir_s.
- Outputs are registered, decoded from the state:
  - led = 1 in AUTO_ON and MANUAL_ON.
  - mode = 1 in MANUAL_*.
  - timer_en = 1 only in AUTO_ON with ir_s=0.
- Counter widths: $clog2(max(DEBOUNCE_T, SWITCH_T))+1 bits. The hold counter saturates and never wraps.

## Timing
- Reset (rst=0): classifier in RELEASED, main FSM in AUTO_OFF, counters and synchronizers cleared. led=0, mode=0, timer_en=0 while reset is held and in the first cycle after release.
- Press latency: the press is accepted at 2 + DEBOUNCE_T cycles after the button rises.
- Long-press latency: long_evt fires SWITCH_T cycles after acceptance. mode/led change 1 cycle after the event pulse.
- Short-press latency: short_evt fires 2 + DEBOUNCE_T cycles after the button falls. led toggles 1 cycle later.
- Presence latency: led rises 3 cycles after infravermelho rises (sync + state + output register).
- Expiry latency: led falls 1 cycle after the timer_expired pulse. timer_en falls in the same cycle as led.
- Reset asserted mid-press or mid-debounce aborts the press; no event is emitted after release.

## Structure
- Package lighting_pkg holds press_state_t and light_state_t enums, plus the default constants for DEBOUNCE_T and SWITCH_T.
- Sub-module button_press_classifier: synchronizer, debounce counter, hold counter and press FSM. It outputs short_evt and long_evt.
- The top contains the main FSM, the presence synchronizer and the output registers.
- The timer itself stays external.

## Test plan
All scenarios use DEBOUNCE_T=4, SWITCH_T=20.
- Reset: hold rst=0 for 5 cycles with all inputs toggling → led=0, mode=0, timer_en=0 throughout and for 1 cycle after release.
- Presence cycle: infravermelho=1 for 10 cycles, then 0 → led=1 3 cycles after the rise; timer_en=1 from 2 cycles after the fall. A timer_expired pulse then gives led=0 and timer_en=0 1 cycle later.
- Bounce rejection: button pulses of 2 cycles high / 2 low, ×10 → no event; mode and led unchanged.
- Long press and manual toggle:
  - Hold the button 30 cycles → mode=1 and led=0 exactly 2+4+20+1 cycles after the press. No short_evt on release.
  - A subsequent 8-cycle press → led=1 after release plus 2+4+1 cycles.
- Collision: in AUTO_ON with ir_s=0, drive timer_expired in the same cycle as long_evt → next state MANUAL_OFF; mode=1, led=0.
- Ignored inputs:
  - In manual mode, timer_expired and infravermelho pulses → led unchanged, timer_en=0.
  - A short press in auto mode → led unchanged.
